// File: rtl/krnl_acc_seq_ctrl.sv
// Job sequencer for the conv accelerator: ap_ctrl_chain handshake, chunked DMA read/write commands, core start.
// Build macro ACC_SEQ_PERF_CNT_EN adds a per-job cycle counter on perf_cycles/perf_valid.
module krnl_acc_seq_ctrl #(
  parameter int CHUNK_BYTES = 4096,
  parameter int LEN_W       = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             ap_start,
  input  logic             ap_continue,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [31:0]      cfg_ci,
  input  logic [31:0]      cfg_co,
  input  logic [LEN_W-1:0] ifm_size,
  input  logic [LEN_W-1:0] wgt_size,
  input  logic [LEN_W-1:0] ofm_size,
  input  logic [63:0]      ifm_addr_base,
  input  logic [63:0]      wgt_addr_base,
  input  logic [63:0]      ofm_addr_base,
  output logic             rd_cmd_valid,
  input  logic             rd_cmd_ready,
  output logic [63:0]      rd_cmd_addr,
  output logic [LEN_W-1:0] rd_cmd_len,
  output logic             rd_cmd_sel,
  input  logic             rd_done,
  output logic             core_start,
  output logic [31:0]      core_ci,
  output logic [31:0]      core_co,
  input  logic             core_done,
  output logic             wr_cmd_valid,
  input  logic             wr_cmd_ready,
  output logic [63:0]      wr_cmd_addr,
  output logic [LEN_W-1:0] wr_cmd_len,
  input  logic             wr_done
`ifdef ACC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic             perf_valid
`endif
);

  typedef enum logic [2:0] {IDLE, LD_WGT, LD_IFM, COMPUTE, STORE, DONE} state_t;

  localparam logic [LEN_W-1:0] CHUNK = LEN_W'(CHUNK_BYTES);

  state_t state, state_nxt;

  logic [LEN_W-1:0] ifm_size_q, ofm_size_q;
  logic [63:0]      ifm_base_q, ofm_base_q;

  // One command engine is shared by all three transfer phases.
  logic [63:0]      cur_addr, cmd_addr, addr_after;
  logic [LEN_W-1:0] remaining, rem_after, cmd_len;
  logic [LEN_W-1:0] issued, completed;
  logic             cmd_valid;

  logic accept, in_rd, in_wr, in_phase, cmd_fire, done_seen, phase_end;

  function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] r);
    return (r > CHUNK) ? CHUNK : r;
  endfunction

  assign accept     = (state == IDLE) && ap_start;
  assign in_rd      = (state == LD_WGT) || (state == LD_IFM);
  assign in_wr      = (state == STORE);
  assign in_phase   = in_rd || in_wr;
  assign cmd_fire   = cmd_valid && (in_rd ? rd_cmd_ready : (in_wr && wr_cmd_ready));
  assign done_seen  = (in_rd && rd_done) || (in_wr && wr_done);
  assign phase_end  = in_phase && (remaining == '0) && (completed == issued) && !cmd_valid;
  assign rem_after  = remaining - cmd_len;
  assign addr_after = cur_addr + 64'(cmd_len);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ap_start)    state_nxt = LD_WGT;
      LD_WGT:  if (phase_end)   state_nxt = LD_IFM;
      LD_IFM:  if (phase_end)   state_nxt = COMPUTE;
      COMPUTE: if (core_done)   state_nxt = STORE;
      STORE:   if (phase_end)   state_nxt = DONE;
      DONE:    if (ap_continue) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
    ap_idle      = (state == IDLE);
    ap_done      = (state == DONE);
    ap_ready     = accept;
    rd_cmd_valid = 1'b0;
    rd_cmd_addr  = '0;
    rd_cmd_len   = '0;
    rd_cmd_sel   = 1'b0;
    wr_cmd_valid = 1'b0;
    wr_cmd_addr  = '0;
    wr_cmd_len   = '0;
    if (in_rd) begin
      rd_cmd_valid = cmd_valid;
      rd_cmd_addr  = cmd_addr;
      rd_cmd_len   = cmd_len;
      rd_cmd_sel   = (state == LD_IFM);
    end
    if (in_wr) begin
      wr_cmd_valid = cmd_valid;
      wr_cmd_addr  = cmd_addr;
      wr_cmd_len   = cmd_len;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ifm_size_q <= '0;
      ofm_size_q <= '0;
      ifm_base_q <= '0;
      ofm_base_q <= '0;
      core_ci    <= '0;
      core_co    <= '0;
      core_start <= 1'b0;
      cur_addr   <= '0;
      remaining  <= '0;
      issued     <= '0;
      completed  <= '0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
    end else begin
      core_start <= (state_nxt == COMPUTE) && (state != COMPUTE);
      if (accept) begin
        ifm_size_q <= ifm_size;
        ofm_size_q <= ofm_size;
        ifm_base_q <= ifm_addr_base;
        ofm_base_q <= ofm_addr_base;
        core_ci    <= cfg_ci;
        core_co    <= cfg_co;
        // The weight phase starts next cycle, so its size/base load straight into the engine.
        cur_addr   <= wgt_addr_base;
        remaining  <= wgt_size;
        issued     <= '0;
        completed  <= '0;
        cmd_valid  <= 1'b0;
      end else if (phase_end) begin
        issued    <= '0;
        completed <= '0;
        if (state == LD_WGT) begin
          cur_addr  <= ifm_base_q;
          remaining <= ifm_size_q;
        end
      end else if (state == COMPUTE && core_done) begin
        cur_addr  <= ofm_base_q;
        remaining <= ofm_size_q;
      end else if (in_phase) begin
        if (done_seen) completed <= completed + 1'b1;
        if (cmd_fire) begin
          cur_addr  <= addr_after;
          remaining <= rem_after;
          issued    <= issued + 1'b1;
          // Present the next chunk immediately so a ready-high target sees back-to-back commands.
          cmd_valid <= (rem_after != '0);
          cmd_addr  <= addr_after;
          cmd_len   <= chunk_of(rem_after);
        end else if (!cmd_valid && remaining != '0) begin
          cmd_valid <= 1'b1;
          cmd_addr  <= cur_addr;
          cmd_len   <= chunk_of(remaining);
        end
      end
    end
  end

`ifdef ACC_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cycle_cnt   <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept)
        cycle_cnt <= '0;
      else if (state != IDLE && state != DONE && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (state_nxt == DONE && state != DONE) perf_cycles <= cycle_cnt;
    end
  end

  assign perf_valid = (state == DONE);
`endif

endmodule

// File: tb/tb_krnl_acc_seq_ctrl.sv
// Scoreboard bench for krnl_acc_seq_ctrl: expected DMA commands come from a chunking model,
// a negedge monitor plays the DMA/core targets and pops/compares on every handshake.
`timescale 1ns/1ps
module tb_krnl_acc_seq_ctrl;

  localparam int CHUNK = 4096;
  localparam int LEN_W = 32;

  typedef struct packed { logic [63:0] addr; logic [31:0] len; logic sel; } cmd_t;
  typedef struct packed { logic [31:0] ci; logic [31:0] co; } cfg_t;

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        ap_start = 1'b0, ap_continue = 1'b0;
  logic        ap_done, ap_idle, ap_ready;
  logic [31:0] cfg_ci = '0, cfg_co = '0;
  logic [31:0] ifm_size = '0, wgt_size = '0, ofm_size = '0;
  logic [63:0] ifm_addr_base = '0, wgt_addr_base = '0, ofm_addr_base = '0;
  logic        rd_cmd_valid, rd_cmd_sel, core_start, wr_cmd_valid;
  logic        rd_cmd_ready = 1'b0, wr_cmd_ready = 1'b0;
  logic        rd_done = 1'b0, wr_done = 1'b0, core_done = 1'b0;
  logic [63:0] rd_cmd_addr, wr_cmd_addr;
  logic [31:0] rd_cmd_len, wr_cmd_len, core_ci, core_co;
`ifdef ACC_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
  logic        perf_valid;
`endif

  krnl_acc_seq_ctrl #(.CHUNK_BYTES(CHUNK), .LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .cfg_ci(cfg_ci), .cfg_co(cfg_co),
    .ifm_size(ifm_size), .wgt_size(wgt_size), .ofm_size(ofm_size),
    .ifm_addr_base(ifm_addr_base), .wgt_addr_base(wgt_addr_base), .ofm_addr_base(ofm_addr_base),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_cmd_sel(rd_cmd_sel), .rd_done(rd_done),
    .core_start(core_start), .core_ci(core_ci), .core_co(core_co), .core_done(core_done),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len), .wr_done(wr_done)
`ifdef ACC_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_valid(perf_valid)
`endif
  );

  initial forever #5 ACLK = ~ACLK;

  // Scoreboard and target-model state
  cmd_t rd_exp[$], wr_exp[$];
  cfg_t cfg_exp[$];
  int   rd_due[$], wr_due[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, rd_last_due = 0, wr_last_due = 0, core_due = -1;
  int   rd_outst = 0, wr_outst = 0, rd_stalls = 0, wr_stalls = 0;
  int   rd_policy = 0, wr_policy = 0, done_delay = 5;
  int   ready_cnt = 0, core_cnt = 0;
  bit   spur_en = 0, exp_idle = 1, prev_done = 0;
  bit   rd_hold = 0, wr_hold = 0, r_rdy = 0, w_rdy = 0;
  logic [63:0] rd_hold_addr, wr_hold_addr;
  logic [31:0] rd_hold_len, wr_hold_len;
  cmd_t mon_cmd;
  cfg_t mon_cfg;
  int   mon_due;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: split a transfer into CHUNK-sized commands, 64-bit wrapping addresses.
  function automatic void push_cmds(input logic [63:0] base, input logic [31:0] size,
                                    input logic sel, input bit is_wr);
    logic [31:0] left = size;
    logic [63:0] a    = base;
    cmd_t        c;
    while (left != 0) begin
      c.len  = (left > CHUNK) ? CHUNK : left;
      c.addr = a;
      c.sel  = sel;
      if (is_wr) wr_exp.push_back(c);
      else       rd_exp.push_back(c);
      a    += 64'(c.len);
      left -= c.len;
    end
  endfunction

  function automatic bit pick_ready(input int pol, input logic valid, input int stalls);
    case (pol)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 9) < 6);
      default: return !(valid && stalls < 10);
    endcase
  endfunction

  function automatic int next_due(input int last);
    int d = (done_delay > 0) ? done_delay : int'($urandom_range(1, 8));
    return (cyc + d <= last) ? last + 1 : cyc + d;
  endfunction

  // Monitor + DMA/core target models. Drives the DUT inputs for the coming rising edge.
  initial forever begin
    @(negedge ACLK);
    if (!ARESETn) begin
      rd_exp.delete(); wr_exp.delete(); cfg_exp.delete(); rd_due.delete(); wr_due.delete();
      rd_outst = 0; wr_outst = 0; rd_stalls = 0; wr_stalls = 0; rd_hold = 0; wr_hold = 0;
      rd_last_due = 0; wr_last_due = 0; core_due = -1; exp_idle = 1; prev_done = 0;
      rd_cmd_ready = 0; wr_cmd_ready = 0; rd_done = 0; wr_done = 0; core_done = 0;
    end else begin
      cyc++;
      check("ap_idle", ap_idle, exp_idle);
      if (ap_ready) begin ready_cnt++; exp_idle = 0; end
      if (ap_done && ap_continue) exp_idle = 1;
      if (ap_done && !prev_done) begin
        check("wr_outstanding_at_done", wr_outst, 0);
        check("wr_cmds_left_at_done", wr_exp.size(), 0);
      end
      prev_done = ap_done;

      rd_done = 0;
      if (rd_due.size() > 0 && rd_due[0] == cyc) begin void'(rd_due.pop_front()); rd_done = 1; rd_outst--; end
      wr_done = 0;
      if (wr_due.size() > 0 && wr_due[0] == cyc) begin void'(wr_due.pop_front()); wr_done = 1; wr_outst--; end

      if (rd_hold) begin
        check("rd_hold_valid", rd_cmd_valid, 1);
        check("rd_hold_addr", rd_cmd_addr, rd_hold_addr);
        check("rd_hold_len", rd_cmd_len, rd_hold_len);
      end
      r_rdy = pick_ready(rd_policy, rd_cmd_valid, rd_stalls);
      rd_cmd_ready = r_rdy;
      rd_hold = rd_cmd_valid && !r_rdy;
      if (rd_hold) begin rd_stalls++; rd_hold_addr = rd_cmd_addr; rd_hold_len = rd_cmd_len; end
      if (rd_cmd_valid && r_rdy) begin
        rd_stalls = 0;
        check("rd_cmd_expected", rd_exp.size() != 0, 1);
        if (rd_exp.size() != 0) begin
          mon_cmd = rd_exp.pop_front();
          check("rd_cmd", {rd_cmd_addr, rd_cmd_len, rd_cmd_sel}, mon_cmd);
        end
        rd_outst++;
        mon_due = next_due(rd_last_due); rd_last_due = mon_due; rd_due.push_back(mon_due);
      end

      if (wr_hold) begin
        check("wr_hold_valid", wr_cmd_valid, 1);
        check("wr_hold_addr", wr_cmd_addr, wr_hold_addr);
        check("wr_hold_len", wr_cmd_len, wr_hold_len);
      end
      w_rdy = pick_ready(wr_policy, wr_cmd_valid, wr_stalls);
      wr_cmd_ready = w_rdy;
      wr_hold = wr_cmd_valid && !w_rdy;
      if (wr_hold) begin wr_stalls++; wr_hold_addr = wr_cmd_addr; wr_hold_len = wr_cmd_len; end
      if (wr_cmd_valid && w_rdy) begin
        wr_stalls = 0;
        check("wr_cmd_expected", wr_exp.size() != 0, 1);
        if (wr_exp.size() != 0) begin
          mon_cmd = wr_exp.pop_front();
          check("wr_cmd", {wr_cmd_addr, wr_cmd_len, 1'b0}, mon_cmd);
        end
        wr_outst++;
        mon_due = next_due(wr_last_due); wr_last_due = mon_due; wr_due.push_back(mon_due);
      end

      if (core_start) begin
        core_cnt++;
        check("rd_outstanding_at_compute", rd_outst, 0);
        check("rd_cmds_left_at_compute", rd_exp.size(), 0);
        check("core_cfg_expected", cfg_exp.size() != 0, 1);
        if (cfg_exp.size() != 0) begin
          mon_cfg = cfg_exp.pop_front();
          check("core_cfg", {core_ci, core_co}, mon_cfg);
        end
        core_due = cyc + int'($urandom_range(1, 6));
      end
      core_done = (core_due == cyc);
      if (core_done) core_due = -1;

      // Done pulses aimed at a phase that is not active must be ignored.
      if (spur_en && wr_outst > 0 && $urandom_range(0, 3) == 0) rd_done = 1;
      if (spur_en && rd_outst > 0 && $urandom_range(0, 3) == 0) wr_done = 1;
      if (spur_en && rd_outst > 0 && $urandom_range(0, 3) == 0) core_done = 1;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle_done_ready"}, {ap_idle, ap_done, ap_ready, core_start}, 4'b1000);
    check({tag, "_rd_cmd"}, {rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_sel}, '0);
    check({tag, "_wr_cmd"}, {wr_cmd_valid, wr_cmd_addr, wr_cmd_len}, '0);
    check({tag, "_core_cfg"}, {core_ci, core_co}, '0);
  endtask

  task automatic start_job(input logic [31:0] wsz, input logic [31:0] isz, input logic [31:0] osz,
                           input logic [63:0] wb, input logic [63:0] ib, input logic [63:0] ob,
                           input bit hold);
    logic [31:0] ci = $urandom;
    logic [31:0] co = $urandom;
    @(posedge ACLK); #1;
    ready_cnt = 0; core_cnt = 0;
    wgt_size = wsz; ifm_size = isz; ofm_size = osz;
    wgt_addr_base = wb; ifm_addr_base = ib; ofm_addr_base = ob;
    cfg_ci = ci; cfg_co = co;
    push_cmds(wb, wsz, 1'b0, 1'b0);
    push_cmds(ib, isz, 1'b1, 1'b0);
    push_cmds(ob, osz, 1'b0, 1'b1);
    cfg_exp.push_back({ci, co});
    ap_start = 1;
    @(negedge ACLK);
    check("ap_ready_on_start", ap_ready, 1);
    @(posedge ACLK); #1;
    // Inputs must have been latched at accept; scramble them to prove it.
    wgt_size = $urandom; ifm_size = $urandom; ofm_size = $urandom;
    wgt_addr_base = {$urandom, $urandom}; ifm_addr_base = {$urandom, $urandom};
    ofm_addr_base = {$urandom, $urandom}; cfg_ci = $urandom; cfg_co = $urandom;
    if (!hold) ap_start = 0;
    @(negedge ACLK);
    check("no_cmd_first_cycle", rd_cmd_valid, 0);
    @(negedge ACLK);
    if (wsz != 0) check("rd_valid_latency_2", rd_cmd_valid, 1);
  endtask

  task automatic finish_job();
    int n = 0;
    while (!ap_done && n < 3000) begin @(negedge ACLK); n++; end
    check("job_reaches_done", ap_done, 1);
    @(posedge ACLK); #1 ap_start = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      check("ap_done_held", ap_done, 1);
    end
    @(posedge ACLK); #1 ap_continue = 1;
    @(posedge ACLK); #1 ap_continue = 0;
    @(negedge ACLK);
    check("ap_done_cleared", ap_done, 0);
    check("ap_ready_pulses", ready_cnt, 1);
    check("core_start_pulses", core_cnt, 1);
    check("rd_cmds_left", rd_exp.size(), 0);
    check("wr_cmds_left", wr_exp.size(), 0);
    check("rd_outstanding_end", rd_outst, 0);
    check("wr_outstanding_end", wr_outst, 0);
  endtask

  function automatic logic [31:0] rand_size();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'($urandom_range(1, 32'h400));
      2:       return 32'($urandom_range(1, 4) * CHUNK);
      default: return 32'($urandom_range(1, 32'h5000));
    endcase
  endfunction

  initial begin
    int n;
    logic [63:0] near_wrap;
    near_wrap = 64'hFFFF_FFFF_FFFF_F800;
    repeat (3) @(posedge ACLK);
    #1 check_reset_outputs("por");
    ARESETn = 1;

    // Basic job, ready high, done 5 cycles after each command
    rd_policy = 0; wr_policy = 0; done_delay = 5;
    start_job(32'h1000, 32'h2800, 32'h800, 64'h1_0000_0000, 64'h2_0000_0000, 64'h3_0000_0000, 0);
    finish_job();

    // Backpressure: 10 stall cycles before every command handshake
    rd_policy = 2; wr_policy = 2; done_delay = 0;
    start_job(32'h1800, 32'h1000, 32'h1000, 64'h4000, 64'h8000, 64'hC000, 0);
    finish_job();

    // Zero weight and output sizes
    rd_policy = 1; wr_policy = 1; done_delay = 3;
    start_job(32'h0, 32'h1234, 32'h0, 64'h100, 64'h2000, 64'h3000, 0);
    finish_job();

    // Completion pulse on the same edge as every subsequent handshake, including the last
    rd_policy = 0; wr_policy = 0; done_delay = 1;
    start_job(32'h2000, 32'h3000, 32'h2000, 64'hA000, 64'hB000, 64'hC000, 0);
    finish_job();

    // ap_start held high through the whole job, plus 64-bit address wrap
    done_delay = 2;
    start_job(32'h1000, 32'h10, 32'h1001, near_wrap, 64'h0, near_wrap, 1);
    finish_job();

    // Asynchronous reset in the middle of STORE
    rd_policy = 0; wr_policy = 2; done_delay = 4;
    start_job(32'h100, 32'h100, 32'h4000, 64'h1000, 64'h2000, 64'h3000, 0);
    n = 0;
    while (!wr_cmd_valid && n < 3000) begin @(negedge ACLK); n++; end
    check("reached_store", wr_cmd_valid, 1);
    @(posedge ACLK); #2 ARESETn = 0;
    #1 check_reset_outputs("mid_store_rst");
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #1 ARESETn = 1;
    rd_policy = 0; wr_policy = 0; done_delay = 5;
    start_job(32'h1000, 32'h2800, 32'h800, 64'h1_0000_0000, 64'h2_0000_0000, 64'h3_0000_0000, 0);
    finish_job();

    // Randomised jobs with stray done pulses
    spur_en = 1;
    for (int j = 0; j < 8; j++) begin
      rd_policy  = int'($urandom_range(0, 2));
      wr_policy  = int'($urandom_range(0, 2));
      done_delay = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
      start_job(rand_size(), rand_size(), rand_size(),
                ($urandom_range(0, 3) == 0) ? near_wrap : {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}, bit'($urandom_range(0, 1)));
      finish_job();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/krnl_acc_seq_ctrl.md
Name: krnl_acc_seq_ctrl

Overview:
Top-level sequencer for the convolution accelerator kernel. It sits between the AXI-Lite control slave (ap_ctrl_chain handshake, config and base-address registers) and the datapath. For each ap_start it issues chunked DMA read commands for weights and then the input feature map, starts the conv core, and issues chunked DMA write commands for the output feature map. Completion is reported back through ap_done/ap_ready/ap_idle.

Parameters:
CHUNK_BYTES, 4096, maximum bytes per DMA command; power of two, at least 64
LEN_W, 32, width of the size and length fields

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ap_start  in  1  start request from the control slave (level)
ap_continue  in  1  one-cycle pulse; acknowledges ap_done
ap_done  out  1  job complete; held until ap_continue
ap_idle  out  1  high only in IDLE
ap_ready  out  1  one-cycle pulse when a job is accepted
cfg_ci, cfg_co  in  32 each  channel configuration, passed to the core
ifm_size, wgt_size, ofm_size  in  LEN_W each  transfer sizes in bytes
ifm_addr_base, wgt_addr_base, ofm_addr_base  in  64 each  DDR base addresses
rd_cmd_valid  out  1  read command valid
rd_cmd_ready  in  1  read command accepted
rd_cmd_addr  out  64  read command byte address
rd_cmd_len  out  LEN_W  read command byte length
rd_cmd_sel  out  1  read target: 0 = weight buffer, 1 = ifm buffer
rd_done  in  1  one-cycle pulse per completed read command
core_start  out  1  one-cycle pulse that starts the conv core
core_ci, core_co  out  32 each  latched cfg_ci / cfg_co
core_done  in  1  one-cycle pulse when the core finishes
wr_cmd_valid  out  1  write command valid
wr_cmd_ready  in  1  write command accepted
wr_cmd_addr  out  64  write command byte address
wr_cmd_len  out  LEN_W  write command byte length
wr_done  in  1  one-cycle pulse per completed write command

Behaviour:
- Reset (asynchronous, any state): state = IDLE; ap_idle = 1; every other output = 0; all counters and latched config = 0.
- States: IDLE, LD_WGT, LD_IFM, COMPUTE, STORE, DONE.
- IDLE, ap_start = 1: ap_ready pulses for that edge. All sizes, addresses and cfg are latched. Next state = LD_WGT. ap_idle drops on the following cycle.
- Load/store phases (LD_WGT, LD_IFM, STORE): cur_addr starts at the base; remaining starts at the size.
  - While remaining > 0, the command is valid with addr = cur_addr and len = min(remaining, CHUNK_BYTES).
  - On valid & ready: cur_addr += len, remaining -= len, issued += 1.
  - Valid, addr and len hold stable until ready is seen.
- Completion counting: every rd_done/wr_done increments completed. The phase ends when remaining == 0 and completed == issued; both counters then clear.
- A size of 0 skips its phase in one cycle with no command issued.
- Commands may overlap completions. A done pulse on the same cycle as a handshake is counted correctly.
- Phase ends route as: LD_WGT -> LD_IFM; LD_IFM -> COMPUTE; STORE -> DONE.
- COMPUTE: core_start pulses on the first cycle. The state then waits for core_done and moves to STORE.
- DONE: ap_done = 1 until ap_continue, then IDLE. ap_start is not sampled in DONE, so a new job begins only after returning to IDLE.
- rd_done, wr_done and core_done arriving in a state that does not expect them are ignored.
- Address arithmetic is 64-bit and wraps modulo 2^64. The length counter is LEN_W wide, unsigned.
- Latency from ap_start to the first rd_cmd_valid: 2 cycles.

Optional Feature:
- Macro ACC_SEQ_PERF_CNT_EN.
- When defined:
  - adds outputs perf_cycles (32) and perf_valid (1);
  - a cycle counter clears on job accept and increments every cycle outside IDLE and DONE, saturating at 0xFFFFFFFF;
  - the count is latched to perf_cycles on entry to DONE;
  - perf_valid is high while in DONE;
  - reset clears all of these.
- When undefined: these ports and the logic do not exist, and behaviour is otherwise identical.

Test Plan:
- Basic job, CHUNK_BYTES = 4096:
  - stimulus: wgt_size = 0x1000, ifm_size = 0x2800, ofm_size = 0x800, ready tied high, done pulses 5 cycles after each command;
  - required: 1 weight read command; ifm reads at base, base+0x1000, base+0x2000 with lengths 0x1000, 0x1000, 0x800; 1 core_start; 1 write command of 0x800; ap_done then held until ap_continue.
- Backpressure: hold rd_cmd_ready low for 10 cycles -> rd_cmd_addr and rd_cmd_len stay unchanged throughout; exactly one handshake per command.
- Zero sizes: wgt_size = 0 and ofm_size = 0 -> no weight read and no write command are issued; sequence goes LD_IFM -> COMPUTE -> DONE.
- Same-cycle events: rd_done coincides with the handshake of the last command -> the phase ends only after the final rd_done, and the completion count matches the issued count.
- Asynchronous reset asserted mid-STORE -> all outputs return to reset values immediately; a new ap_start then runs a full job correctly.
- ap_ready/ap_idle: ap_start held high through a job -> exactly one ap_ready pulse; ap_idle low from the cycle after accept until return to IDLE.
